split_target_mem: RTL
=====================

# split_target_mem

Split-capable memory target attached to the bus's split-target (target 3) interface; the responder at the far end of the initiator protocol. Writes complete in place with an `ack` after a fixed latency. Reads are split: the block releases the bus with `split_ack`, models a slow memory access, then re-requests the bus via `split_req`. On grant it returns the byte with `ack`.

## Interface
- `MEM_ADDR_BITS`, default 12: byte-array index width. Depth is 2^MEM_ADDR_BITS.
- `READ_LATENCY`, default 8: cycles from `split_ack` to `split_req` assertion. Must be ≥1.
- `WRITE_LATENCY`, default 2: cycles from write-data capture to `ack`. Must be ≥1.
- `clk`  in  1  clock; all logic on posedge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `addr_in`  in  16  transaction address. Bits above MEM_ADDR_BITS-1 are ignored (aliasing).
- `addr_in_valid`  in  1  one-cycle strobe qualifying `addr_in` and `rw`.
- `rw`  in  1  direction, sampled with `addr_in_valid`: 1 = write, 0 = read.
- `data_in`  in  8  write byte.
- `data_in_valid`  in  1  one-cycle strobe qualifying `data_in`.
- `split_grant`  in  1  bus grant for the split response.
- `ready`  out  1  high when able to accept a new address.
- `ack`  out  1  one-cycle completion pulse for a write or for read data.
- `split_ack`  out  1  one-cycle pulse: read accepted, bus released.
- `split_req`  out  1  level: requesting the bus to return read data.
- `data_out`  out  8  read byte.
- `data_out_valid`  out  1  one-cycle strobe qualifying `data_out`.

## Operation
- All outputs are registered.
- Reset values: `ready`=1; all other outputs 0, including `data_out`=0x00. Memory contents are not reset and are undefined at power-up.
- State machine states: IDLE, WR_DATA, WR_BUSY, RD_SPLIT, RD_WAIT, RD_REQ, RD_RESP.
- IDLE:
  - `ready`=1.
  - `addr_in_valid` with `rw`=1 and no `data_in_valid` in the same cycle: latch the address, go to WR_DATA.
  - `addr_in_valid` with `rw`=1 and `data_in_valid` in the same cycle: latch both address and data, go to WR_BUSY.
  - `addr_in_valid` with `rw`=0: latch the address, snapshot `mem[addr]` into the read register, go to RD_SPLIT.
  - `ready` drops on the transition out of IDLE.
- WR_DATA: wait indefinitely for `data_in_valid`; latch the data, go to WR_BUSY.
- WR_BUSY:
  - Memory is written on entry.
  - A counter runs WRITE_LATENCY cycles, then `ack` pulses for one cycle.
  - Return to IDLE with `ready`=1 in the cycle after `ack`.
- RD_SPLIT: `split_ack`=1 for one cycle, then go to RD_WAIT.
- RD_WAIT: count READ_LATENCY cycles, then go to RD_REQ with `split_req`=1.
- RD_REQ:
  - Hold `split_req` until `split_grant` is sampled high.
  - Then go to RD_RESP: `data_out`=snapshot, `data_out_valid`=1, `ack`=1, `split_req`=0, all for one cycle.
  - Then go to IDLE.
- Ignored inputs:
  - `addr_in_valid` outside IDLE.
  - `data_in_valid` outside IDLE/WR_DATA.
  - `split_grant` outside RD_REQ, including any grant in the cycle `split_req` first rises from RD_WAIT.
- Snapshot semantics: read data is the memory value at address-capture time. No write can intervene, because `ready`=0 for the whole read.
- Reset mid-operation: immediately return to IDLE with reset output values. A pending read is dropped. Memory retains all bytes already written.

## Timing
- Let T be the cycle in which `addr_in_valid` is sampled.
- Write with data at T: memory updated at edge T+1; `ack` high in cycle T+WRITE_LATENCY+1; `ready`=1 from cycle T+WRITE_LATENCY+2.
- Write with data sampled at cycle D > T: all of the above shift by D−T.
- Read:
  - `split_ack` high in cycle T+1.
  - `split_req` high from cycle T+2+READ_LATENCY.
  - Grant sampled at cycle G: `data_out_valid`/`ack` high in cycle G+1; `ready`=1 from G+2.
- Minimum read-to-read spacing is 4+READ_LATENCY cycles with immediate grant.
- `ack` and `split_ack` are never high in the same cycle.

## Test plan
- Reset release: `ready`=1 and all other outputs 0. Assert `rst_n`=0 mid-RD_WAIT: `split_req` never rises, `ready` returns to 1, previously written bytes remain readable.
- Write 0xA5 to 0x0123 with data in the same cycle as the address (T): `ack` high exactly at cycle T+3 (defaults), one cycle wide.
- Read 0x0123: `split_ack` at T+1; `split_req` at T+10. Grant held low 5 cycles, then high: `data_out`=0xA5 with `data_out_valid`=`ack`=1 for one cycle after the grant; `split_req` falls in that same cycle.
- Write with data 4 cycles after the address: `ack` at T+4+3. A second `addr_in_valid` while busy is ignored (no extra `ack`, memory unchanged).
- Aliasing: write 0x3C to 0xF123, then read 0x0123 → returns 0x3C.
- Spurious `split_grant` pulses during RD_WAIT, and a grant in the cycle `split_req` first rises, produce no response. Data returns only after the next sampled grant.

Source files
------------

// File: rtl/split_target_mem.sv
// split_target_mem
//   Split-capable byte memory on the bus split-target interface.
//   A write completes in place and pulses ack after WRITE_LATENCY cycles.
//   A read releases the bus with split_ack and snapshots the byte.
//   After READ_LATENCY cycles it raises split_req. Once split_grant is
//   sampled, it returns the byte with data_out_valid and ack.
//
// Ports
//   clk            clock, all logic on posedge
//   rst_n          asynchronous active-low reset
//   addr_in        transaction address; bits above MEM_ADDR_BITS-1 alias
//   addr_in_valid  strobe qualifying addr_in / rw (accepted only when ready)
//   rw             1 = write, 0 = read
//   data_in        write byte
//   data_in_valid  strobe qualifying data_in
//   split_grant    bus grant for the split read response
//   ready          able to accept a new address
//   ack            one-cycle completion pulse (write done / read data)
//   split_ack      one-cycle pulse: read accepted, bus released
//   split_req      level: requesting the bus to return read data
//   data_out       read byte
//   data_out_valid one-cycle strobe qualifying data_out
module split_target_mem #(
    parameter int unsigned MEM_ADDR_BITS = 12,
    parameter int unsigned READ_LATENCY  = 8,
    parameter int unsigned WRITE_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] addr_in,
    input  logic        addr_in_valid,
    input  logic        rw,
    input  logic [7:0]  data_in,
    input  logic        data_in_valid,
    input  logic        split_grant,
    output logic        ready,
    output logic        ack,
    output logic        split_ack,
    output logic        split_req,
    output logic [7:0]  data_out,
    output logic        data_out_valid
);

    localparam int unsigned DEPTH = 1 << MEM_ADDR_BITS;
    localparam int unsigned MAXL  = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    localparam int unsigned CW    = $clog2(MAXL + 1);

    localparam logic [CW-1:0] ONE     = CW'(1);
    localparam logic [CW-1:0] WL_LAST = CW'(WRITE_LATENCY - 1);
    localparam logic [CW-1:0] WL_DONE = CW'(WRITE_LATENCY);
    localparam logic [CW-1:0] RL_LAST = CW'(READ_LATENCY - 1);

    typedef enum logic [2:0] {
        IDLE,
        WR_DATA,
        WR_BUSY,
        RD_SPLIT,
        RD_WAIT,
        RD_REQ,
        RD_RESP
    } state_t;

    state_t                   state, state_d;
    logic [CW-1:0]            cnt, cnt_d;
    logic [MEM_ADDR_BITS-1:0] addr_q, addr_d;
    logic [7:0]               wdata_q, wdata_d;
    logic [7:0]               snap;
    logic [7:0]               mem [DEPTH];

    logic                     ready_d;
    logic                     ack_d;
    logic                     split_ack_d;
    logic                     split_req_d;
    logic [7:0]               data_out_d;
    logic                     data_out_valid_d;

    // Upper address bits are deliberately dropped (aliasing).
    generate
        if (MEM_ADDR_BITS < 16) begin : g_alias
            logic unused_addr_bits;
            assign unused_addr_bits = ^addr_in[15:MEM_ADDR_BITS];
        end
    endgenerate

    // Next-state and next-output logic; all outputs are registered below.
    always_comb begin
        state_d          = state;
        cnt_d            = cnt;
        addr_d           = addr_q;
        wdata_d          = wdata_q;
        ready_d          = 1'b0;
        ack_d            = 1'b0;
        split_ack_d      = 1'b0;
        split_req_d      = 1'b0;
        data_out_d       = data_out;
        data_out_valid_d = 1'b0;

        case (state)
            IDLE: begin
                ready_d = 1'b1;
                if (addr_in_valid) begin
                    ready_d = 1'b0;
                    addr_d  = addr_in[MEM_ADDR_BITS-1:0];
                    cnt_d   = '0;
                    if (rw) begin
                        if (data_in_valid) begin
                            wdata_d = data_in;
                            state_d = WR_BUSY;
                        end else begin
                            state_d = WR_DATA;
                        end
                    end else begin
                        split_ack_d = 1'b1;
                        state_d     = RD_SPLIT;
                    end
                end
            end

            WR_DATA: begin
                if (data_in_valid) begin
                    wdata_d = data_in;
                    cnt_d   = '0;
                    state_d = WR_BUSY;
                end
            end

            // cnt==WL_LAST registers ack; the following cycle (cnt==WL_DONE)
            // is the ack cycle itself and returns to IDLE with ready.
            WR_BUSY: begin
                if (cnt == WL_LAST) begin
                    ack_d = 1'b1;
                end
                if (cnt == WL_DONE) begin
                    ready_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt + ONE;
                end
            end

            RD_SPLIT: begin
                cnt_d   = '0;
                state_d = RD_WAIT;
            end

            RD_WAIT: begin
                if (cnt == RL_LAST) begin
                    split_req_d = 1'b1;
                    state_d     = RD_REQ;
                end else begin
                    cnt_d = cnt + ONE;
                end
            end

            RD_REQ: begin
                if (split_grant) begin
                    data_out_d       = snap;
                    data_out_valid_d = 1'b1;
                    ack_d            = 1'b1;
                    state_d          = RD_RESP;
                end else begin
                    split_req_d = 1'b1;
                end
            end

            RD_RESP: begin
                ready_d = 1'b1;
                state_d = IDLE;
            end

            default: begin
                ready_d = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= '0;
            addr_q         <= '0;
            wdata_q        <= '0;
            ready          <= 1'b1;
            ack            <= 1'b0;
            split_ack      <= 1'b0;
            split_req      <= 1'b0;
            data_out       <= '0;
            data_out_valid <= 1'b0;
        end else begin
            state          <= state_d;
            cnt            <= cnt_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            ready          <= ready_d;
            ack            <= ack_d;
            split_ack      <= split_ack_d;
            split_req      <= split_req_d;
            data_out       <= data_out_d;
            data_out_valid <= data_out_valid_d;
        end
    end

    // Storage is not reset so written bytes survive rst_n. The read byte is
    // snapshotted at address capture; ready stays low for the whole read, so
    // no write can change it before it is returned.
    always_ff @(posedge clk) begin
        if (state == WR_BUSY && cnt == '0) begin
            mem[addr_q] <= wdata_q;
        end
        if (state == IDLE && addr_in_valid && !rw) begin
            snap <= mem[addr_in[MEM_ADDR_BITS-1:0]];
        end
    end

endmodule
